alu_md: RTL
===========

// Module: alu_md
// PURPOSE
//  Parametrised datapath ALU for the MIPS core with an iterative multiply/divide unit and HI/LO registers.
//  Single-cycle ops are combinational, as in the EX stage today.
//  MULT/MULTU/DIV/DIVU run over WIDTH cycles behind a start/busy/done handshake; the control unit stalls on busy.
// PARAMETERS
//  WIDTH  32  operand/result width; >=8, power of two
//  SHW    $clog2(WIDTH)  shift-amount width (derived; do not override)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  A         in   WIDTH  operand A (rs, or shamt zero-extended for shifts)
//  B         in   WIDTH  operand B (rt or immediate)
//  ALUOp     in   5      operation, `ALUOp_* from ctrl_encode_def.v
//  start     in   1      launch mul/div when ALUOp is a mul/div op; ignored otherwise
//  C         out  WIDTH  combinational result
//  zero      out  1      branch/compare flag
//  overflow  out  1      signed overflow for ADD/SUB only
//  busy      out  1      mul/div in progress
//  done      out  1      one-cycle pulse: HI/LO just updated
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset: hi=lo=0, busy=0, done=0, FSM=IDLE, count=0. C/zero/overflow are combinational, never registered.
//  Combinational ops, latency 0:
//   ADDU/SUBU: A+-B mod 2^WIDTH. ADD/SUB: same C; overflow = signed overflow.
//   AND/OR/XOR/NOR: bitwise.
//   SLT signed, SLTU unsigned: C = {0..,1} when A<B.
//   SLL/SRL/SRA: C = B shifted by A[SHW-1:0]; SRA sign-fills.
//   LUI: C = B << (WIDTH/2).
//   MFHI/MFLO: C = hi/lo.
//  zero flag: EQL -> (A==B); NE -> (A!=B); every other op -> (C==0). Undefined ALUOp: C=0, zero=1, overflow=0.
//  MTHI/MTLO: on the clk edge with ALUOp=MTHI/MTLO and busy=0, hi<=A or lo<=A. Ignored while busy.
//  Mul/div FSM, states IDLE -> RUN -> DONE -> IDLE:
//   IDLE: start & mul/div op latches A, B, op and signs; count<=WIDTH-1; -> RUN.
//   RUN: busy=1, one radix-2 step per cycle (shift-add multiply; restoring divide on magnitudes).
//        At count==0: sign-correct the result, write hi/lo, -> DONE; otherwise count--.
//   DONE: done=1, busy=0 for exactly one cycle; -> IDLE. A start in DONE is ignored.
//  Latency: start sampled at edge k; busy high in cycles k+1..k+WIDTH; hi/lo valid and done=1 in cycle k+WIDTH+1.
//  Results:
//   MULT/MULTU: {hi,lo} = full 2*WIDTH product.
//   DIV/DIVU: lo = quotient, hi = remainder. Signed: quotient truncates toward zero; remainder takes the sign of A.
//  Divide by zero: completes with normal latency; lo = all ones, hi = A. No trap.
//  Signed MIN / -1: lo = MIN, hi = 0.
//  Operand/ALUOp changes while busy do not affect the running op (operands latched).
//  C remains live for the combinational ops while busy. MFHI/MFLO while busy returns the old hi/lo; the control unit must stall.
//  start while busy: ignored; no queueing.
//  rst mid-operation: immediate abort to IDLE; hi/lo cleared; no done pulse.
// STRUCTURE
//  ctrl_encode_def.v (shared) gains these ALUOp codes:
//   ADD, SUB, AND, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, NE,
//   MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
//  Existing ADDU/SUBU/OR/EQL codes are unchanged.
//  One sub-module: muldiv_iter (WIDTH). It holds the FSM, counter, operand/accumulator registers and hi/lo.
//  alu_md keeps the combinational case statement and the output muxing.
// TESTING
//  1. WIDTH=32: ADDU 0xFFFFFFFF+1 -> C=0, zero=1. ADD 0x7FFFFFFF+1 -> C=0x80000000, overflow=1.
//  2. SLT A=-1, B=1 -> C=1. SLTU same operands -> C=0. SRA B=0x80000000, A=4 -> C=0xF8000000. EQL 5,5 -> zero=1.
//  3. MULT A=-3, B=7, start pulse -> busy for 32 cycles, then done for 1 cycle; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//     MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=1.
//  4. DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=9, B=0 -> lo=0xFFFFFFFF, hi=9.
//     Second start pulse mid-op -> ignored; done fires exactly once.
//  5. rst asserted at RUN cycle 10, async between edges -> busy=0, hi=lo=0 immediately; no done.
//     Next MTLO A=0x1234 -> lo=0x1234.
//  6. Parameter sweep: WIDTH=8 and 16 with 500 random mul/div ops each vs a reference model.
//     Check latency = WIDTH+1 and hi/lo results.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared ALU operation codes and mul/div unit types for the MIPS EX-stage ALU.
// Undefined codes (24..31) produce C=0, zero=1, overflow=0.
package alu_md_pkg;

    localparam logic [4:0] ALUOP_ADD   = 5'd0;
    localparam logic [4:0] ALUOP_ADDU  = 5'd1;
    localparam logic [4:0] ALUOP_SUB   = 5'd2;
    localparam logic [4:0] ALUOP_SUBU  = 5'd3;
    localparam logic [4:0] ALUOP_AND   = 5'd4;
    localparam logic [4:0] ALUOP_OR    = 5'd5;
    localparam logic [4:0] ALUOP_XOR   = 5'd6;
    localparam logic [4:0] ALUOP_NOR   = 5'd7;
    localparam logic [4:0] ALUOP_SLT   = 5'd8;
    localparam logic [4:0] ALUOP_SLTU  = 5'd9;
    localparam logic [4:0] ALUOP_SLL   = 5'd10;
    localparam logic [4:0] ALUOP_SRL   = 5'd11;
    localparam logic [4:0] ALUOP_SRA   = 5'd12;
    localparam logic [4:0] ALUOP_LUI   = 5'd13;
    localparam logic [4:0] ALUOP_EQL   = 5'd14;
    localparam logic [4:0] ALUOP_NE    = 5'd15;
    // Mul/div codes share their low two bits with md_op_e.
    localparam logic [4:0] ALUOP_MULT  = 5'd16;
    localparam logic [4:0] ALUOP_MULTU = 5'd17;
    localparam logic [4:0] ALUOP_DIV   = 5'd18;
    localparam logic [4:0] ALUOP_DIVU  = 5'd19;
    localparam logic [4:0] ALUOP_MFHI  = 5'd20;
    localparam logic [4:0] ALUOP_MFLO  = 5'd21;
    localparam logic [4:0] ALUOP_MTHI  = 5'd22;
    localparam logic [4:0] ALUOP_MTLO  = 5'd23;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op >= ALUOP_MULT) && (op <= ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Works on magnitudes and sign-corrects on the final step.
module muldiv_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_e          state, state_nxt;
    logic [CW-1:0]      count;
    md_op_e             op_q;
    logic               sa_q, neg_q, div0_q;
    logic [WIDTH-1:0]   a_q, opnd_q;
    logic [2*WIDTH-1:0] acc_q, acc_step, result;
    logic [WIDTH:0]     sum, shifted, trial;
    logic               launch, finish, sgn_op, sa, sb;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_sign(input md_op_e o, input logic [2*WIDTH-1:0] raw,
                                                    input logic neg, input logic sgn_a,
                                                    input logic div0, input logic [WIDTH-1:0] a_orig);
        logic [WIDTH-1:0] q, r;
        if (o == MD_MULT || o == MD_MULTU)
            return neg ? -raw : raw;
        if (div0)
            return {a_orig, {WIDTH{1'b1}}};
        q = neg   ? -raw[WIDTH-1:0]       : raw[WIDTH-1:0];
        r = sgn_a ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        return {r, q};
    endfunction

    assign launch = (state == MD_IDLE) && start;
    assign finish = (state == MD_RUN) && (count == '0);
    assign busy   = (state == MD_RUN);
    assign done   = (state == MD_DONE);
    assign sgn_op = (op == MD_MULT) || (op == MD_DIV);
    assign sa     = sgn_op & a[WIDTH-1];
    assign sb     = sgn_op & b[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (launch)
                count <= CW'(WIDTH - 1);
            else if (state == MD_RUN && count != '0)
                count <= count - CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_RUN;
            MD_RUN:  if (count == '0) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};
        if (op_q == MD_MULT || op_q == MD_MULTU)
            acc_step = {sum, acc_q[WIDTH-1:1]};
        else if (trial[WIDTH])
            acc_step = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        result = fix_sign(op_q, acc_step, neg_q, sa_q, div0_q, a_q);
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            op_q   <= op;
            sa_q   <= sa;
            neg_q  <= sa ^ sb;
            a_q    <= a;
            div0_q <= (b == '0);
            if (op == MD_MULT || op == MD_MULTU) begin
                opnd_q <= mag(a, sa);
                acc_q  <= {{WIDTH{1'b0}}, mag(b, sb)};
            end else begin
                opnd_q <= mag(b, sb);
                acc_q  <= {{WIDTH{1'b0}}, mag(a, sa)};
            end
        end else if (state == MD_RUN) begin
            acc_q <= acc_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
        end else if (state != MD_RUN) begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: combinational single-cycle ops plus an iterative mul/div unit with HI/LO.
// C, zero and overflow are purely combinational; mul/div results appear only on hi/lo.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUOp,
    input  logic             start,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        sum, diff;
    logic [SHW-1:0]          shamt;

    assign a_s   = A;
    assign b_s   = B;
    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = A[SHW-1:0];

    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (start && is_md_op(ALUOp)),
        .op    (md_op_e'(ALUOp[1:0])),
        .a     (A),
        .b     (B),
        .mthi  (ALUOp == ALUOP_MTHI),
        .mtlo  (ALUOp == ALUOP_MTLO),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always_comb begin
        C        = '0;
        overflow = 1'b0;
        case (ALUOp)
            ALUOP_ADD: begin
                C        = sum;
                overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALUOP_ADDU: C = sum;
            ALUOP_SUB: begin
                C        = diff;
                overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALUOP_SUBU: C = diff;
            ALUOP_AND:  C = A & B;
            ALUOP_OR:   C = A | B;
            ALUOP_XOR:  C = A ^ B;
            ALUOP_NOR:  C = ~(A | B);
            ALUOP_SLT:  C = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALUOP_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALUOP_SLL:  C = B << shamt;
            ALUOP_SRL:  C = B >> shamt;
            ALUOP_SRA:  C = b_s >>> shamt;
            ALUOP_LUI:  C = B << (WIDTH / 2);
            ALUOP_EQL:  C = diff;
            ALUOP_NE:   C = diff;
            ALUOP_MFHI: C = hi;
            ALUOP_MFLO: C = lo;
            default:    C = '0;
        endcase

        // Branch compares look at operands directly; everything else flags a zero result.
        if (ALUOp == ALUOP_EQL)
            zero = (A == B);
        else if (ALUOp == ALUOP_NE)
            zero = (A != B);
        else
            zero = (C == '0);
    end

endmodule
